vga_scene_gen: RTL
==================

# vga_scene_gen

Parametrised, animated successor to the static background pixel generator in the street-fighter VGA path. It sits between the VGA display controller (`hCount`/`vCount`/`bright`) and the sprite compositor. It draws sky, horizon blades and striped grass with a configurable horizon, and adds per-frame horizontal grass scrolling and a four-phase day/night colour cycle. Output is registered with one cycle of latency.

## Interface
- `HORIZON_Y`, default 394: first grass row; sky occupies rows below this value.
- `BLADE_H`, default 5: blade rows directly above the horizon (rows `HORIZON_Y-BLADE_H` … `HORIZON_Y-1`).
- `SCROLL_STEP`, default 1: pixels added to the scroll offset per frame.
- `FRAMES_PER_PHASE`, default 600: frames spent in each day/night phase; must be ≥1.
- `DWELL_W`, default 10: dwell counter width; must satisfy `2^DWELL_W > FRAMES_PER_PHASE`.
- `clk`  in  1: pixel-domain clock, single clock domain.
- `reset`  in  1: asynchronous, active-low reset.
- `bright`  in  1: active-video flag from the display controller.
- `hCount`  in  10: current horizontal pixel.
- `vCount`  in  10: current vertical line.
- `scroll_en`  in  1: enables scroll advance on frame tick.
- `cycle_en`  in  1: enables day/night dwell counting.
- `phase`  out  2: current phase (0 DAY, 1 DUSK, 2 NIGHT, 3 DAWN).
- `rgb`  out  12: {R[3:0], G[3:0], B[3:0]}, registered.

## Operation
- Frame tick: one-cycle internal pulse when `hCount==0 && vCount==0` and the previous cycle was not at the origin. Fires exactly once per frame, even if the origin is held for several clocks.
- Scroll: 10-bit `scroll_off`. On tick with `scroll_en` high, `scroll_off += SCROLL_STEP` (mod 1024). Scrolled x is `xs = hCount + scroll_off` (mod 1024). `xs` feeds blade columns and grass stripes only. Sky is not scrolled.
- Phase FSM: DAY→DUSK→NIGHT→DAWN→DAY.
  - A dwell counter increments on tick while `cycle_en` is high.
  - When the counter reaches `FRAMES_PER_PHASE-1` on a tick, it clears and the phase advances.
  - While `cycle_en` is low, both the counter and the phase hold.
  - Phase and scroll change only on tick, so no mid-frame tearing.
- Pixel classes, in priority order:
  1. `!bright` → 0x000.
  2. Blade: row within the `BLADE_H` rows below `HORIZON_Y`, and (`xs%5==0 || xs%12==0 || xs%18==0`) → grass colour.
  3. `vCount < HORIZON_Y` → sky colour.
  4. Otherwise → grass colour.
- Sky colour, with `g = vCount>>4`:
  - DAY: R 0, G 0, B `min(15, g+2)`.
  - DUSK: R 6, G 0, B `min(15, g)`.
  - NIGHT: R 0, G 0, B `min(4, vCount>>5)`.
  - DAWN: R 3, G 0, B `min(15, g+1)`.
- Grass colour: R 0, B 1, G = base + (`xs[4]^vCount[3]` ? 4 : 0). Base is 4 in NIGHT and 8 in all other phases.
- Arithmetic: clamps are computed at 5-bit width before truncating to 4 bits. No 4-bit overflow is allowed.

## Timing
- Reset (async assert, synchronous release via clk edge): `rgb`=0x000, `phase`=DAY, `scroll_off`=0, dwell=0, origin-history flag=0.
- `rgb` latency: 1 clock from `hCount`/`vCount`/`bright` to output.
- Tick-driven updates: `phase` and `scroll_off` update on the clock edge where tick is high. The first pixel affected is the origin pixel's registered output one cycle later.
- Tick coinciding with a phase change: the new phase and the new scroll value apply together.
- Reset asserted mid-frame: outputs clear immediately. After release, the next origin crossing produces a tick.
- `FRAMES_PER_PHASE==1`: the phase advances on every enabled tick.
- Scroll wrap: `scroll_off=1023`, `SCROLL_STEP=1` → 0.

## Structure
- Package `vga_scene_pkg` holds:
  - the phase enum (DAY/DUSK/NIGHT/DAWN);
  - the colour constants BLACK, grass blue tint, and per-phase sky red/blue offsets and night blue clamp;
  - the blade moduli 5/12/18.
- Sub-module `vga_scene_timebase` contains tick detect, the scroll register, and the dwell counter plus phase FSM. It outputs `phase` and `scroll_off`.
- The top level holds the pixel classifier and the output register.

## Test plan
- Reset low mid-line → `rgb`=0x000 and `phase`=0 asynchronously. After release, DAY pixel (h=100, v=50) gives `rgb`=0x005 one cycle later.
- Origin held 3 clocks → exactly one tick. With `scroll_en`=1, `scroll_off` goes 0→1. Blade at h=59, v=390 (xs=60) → green 8 or 12, blue 1.
- `FRAMES_PER_PHASE`=2, `cycle_en`=1, 8 frames → `phase` sequence 0,0,1,1,2,2,3,3, then 0. With `cycle_en` low for 3 frames, the phase holds.
- NIGHT, pixel (h=0, v=300) → `rgb`=0x004. NIGHT grass at h=16, v=400 (stripe bit 1^0) → `rgb`=0x081.
- `bright`=0 at any phase → `rgb`=0x000. DUSK, v=300 → `rgb`=0x60F (B clamped at 15 from 18).
- Scroll wrap: preload via 1023 ticks with `scroll_en`=1 → `scroll_off`=1023; the next tick gives 0. Blade columns at v=390 match the unscrolled pattern.

Source files
------------

// File: rtl/vga_scene_pkg.sv
// Shared types and colour constants for the animated background generator.
// Blade geometry and per-phase sky tints live here so the classifier stays data-driven.
package vga_scene_pkg;

  typedef enum logic [1:0] {
    DAY   = 2'd0,
    DUSK  = 2'd1,
    NIGHT = 2'd2,
    DAWN  = 2'd3
  } phase_e;

  localparam logic [11:0] BLACK         = 12'h000;
  localparam logic [3:0]  GRASS_B       = 4'd1;
  localparam logic [3:0]  GRASS_G_DAY   = 4'd8;
  localparam logic [3:0]  GRASS_G_NIGHT = 4'd4;
  localparam logic [3:0]  GRASS_STRIPE  = 4'd4;

  localparam logic [3:0]  SKY_R_DAY     = 4'd0;
  localparam logic [3:0]  SKY_R_DUSK    = 4'd6;
  localparam logic [3:0]  SKY_R_NIGHT   = 4'd0;
  localparam logic [3:0]  SKY_R_DAWN    = 4'd3;
  localparam logic [6:0]  SKY_B_OFF_DAY  = 7'd2;
  localparam logic [6:0]  SKY_B_OFF_DUSK = 7'd0;
  localparam logic [6:0]  SKY_B_OFF_DAWN = 7'd1;
  localparam logic [4:0]  NIGHT_B_MAX    = 5'd4;

  localparam logic [9:0]  BLADE_M0 = 10'd5;
  localparam logic [9:0]  BLADE_M1 = 10'd12;
  localparam logic [9:0]  BLADE_M2 = 10'd18;

  // Sum is kept wide so the +offset can never wrap before the clamp.
  function automatic logic [3:0] clamp15(input logic [6:0] v);
    return (v > 7'd15) ? 4'd15 : v[3:0];
  endfunction

  function automatic logic blade_col(input logic [9:0] xs);
    return ((xs % BLADE_M0) == 10'd0) || ((xs % BLADE_M1) == 10'd0) ||
           ((xs % BLADE_M2) == 10'd0);
  endfunction

endpackage

// File: rtl/vga_scene_timebase.sv
// Frame tick detect, scroll offset and day/night phase sequencing.
// Effective outputs already reflect this cycle's tick so a whole frame sees one value.
import vga_scene_pkg::*;

module vga_scene_timebase #(
  parameter int SCROLL_STEP      = 1,
  parameter int FRAMES_PER_PHASE = 600,
  parameter int DWELL_W          = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] i_hcount,
  input  logic [9:0] i_vcount,
  input  logic       i_scroll_en,
  input  logic       i_cycle_en,
  output phase_e     o_phase,
  output phase_e     o_phase_eff,
  output logic [9:0] o_scroll_off
);

  logic               r_at_origin;
  logic [9:0]         r_scroll;
  logic [DWELL_W-1:0] r_dwell;
  phase_e             r_phase;
  phase_e             w_phase_nxt;
  logic               w_origin, w_tick, w_dwell_last, w_adv;
  logic [9:0]         w_scroll_nxt;

  assign w_origin     = (i_hcount == 10'd0) && (i_vcount == 10'd0);
  assign w_tick       = w_origin & ~r_at_origin;
  assign w_dwell_last = (r_dwell == DWELL_W'(FRAMES_PER_PHASE - 1));
  assign w_adv        = w_tick & i_cycle_en & w_dwell_last;
  assign w_scroll_nxt = (w_tick & i_scroll_en) ? r_scroll + 10'(SCROLL_STEP) : r_scroll;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_at_origin <= 1'b0;
      r_scroll    <= 10'd0;
      r_dwell     <= '0;
    end else begin
      r_at_origin <= w_origin;
      r_scroll    <= w_scroll_nxt;
      if (w_tick && i_cycle_en)
        r_dwell <= w_dwell_last ? '0 : r_dwell + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_phase <= DAY;
    else        r_phase <= w_phase_nxt;
  end

  always_comb begin
    w_phase_nxt = r_phase;
    if (w_adv) begin
      case (r_phase)
        DAY:     w_phase_nxt = DUSK;
        DUSK:    w_phase_nxt = NIGHT;
        NIGHT:   w_phase_nxt = DAWN;
        default: w_phase_nxt = DAY;
      endcase
    end
  end

  always_comb begin
    o_phase      = r_phase;
    o_phase_eff  = w_phase_nxt;
    o_scroll_off = w_scroll_nxt;
  end

endmodule

// File: rtl/vga_scene_gen.sv
// Animated background: sky, horizon blades and striped grass with scroll and day/night.
// The origin pixel already uses the post-tick phase/scroll, so no frame mixes two values.
import vga_scene_pkg::*;

module vga_scene_gen #(
  parameter int HORIZON_Y        = 394,
  parameter int BLADE_H          = 5,
  parameter int SCROLL_STEP      = 1,
  parameter int FRAMES_PER_PHASE = 600,
  parameter int DWELL_W          = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        scroll_en,
  input  logic        cycle_en,
  output logic [1:0]  phase,
  output logic [11:0] rgb
);

  localparam logic [9:0] HOR_Y     = 10'(HORIZON_Y);
  localparam logic [9:0] BLADE_TOP = 10'(HORIZON_Y - BLADE_H);

  phase_e      w_phase, w_phase_eff;
  logic [9:0]  w_scroll, w_xs;
  logic [6:0]  w_g;
  logic [4:0]  w_nb;
  logic [3:0]  w_night_b, w_sky_r, w_sky_b, w_grass_g;
  logic        w_blade_row;
  logic [11:0] w_grass, w_rgb;
  logic [11:0] r_rgb;

  vga_scene_timebase #(
    .SCROLL_STEP      (SCROLL_STEP),
    .FRAMES_PER_PHASE (FRAMES_PER_PHASE),
    .DWELL_W          (DWELL_W)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (reset),
    .i_hcount     (hCount),
    .i_vcount     (vCount),
    .i_scroll_en  (scroll_en),
    .i_cycle_en   (cycle_en),
    .o_phase      (w_phase),
    .o_phase_eff  (w_phase_eff),
    .o_scroll_off (w_scroll)
  );

  assign w_xs        = hCount + w_scroll;
  assign w_g         = {1'b0, vCount[9:4]};
  assign w_nb        = vCount[9:5];
  assign w_night_b   = (w_nb > NIGHT_B_MAX) ? NIGHT_B_MAX[3:0] : w_nb[3:0];
  assign w_blade_row = (vCount >= BLADE_TOP) && (vCount < HOR_Y);

  always_comb begin
    w_sky_r = SKY_R_DAY;
    w_sky_b = clamp15(w_g + SKY_B_OFF_DAY);
    case (w_phase_eff)
      DUSK: begin
        w_sky_r = SKY_R_DUSK;
        w_sky_b = clamp15(w_g + SKY_B_OFF_DUSK);
      end
      NIGHT: begin
        w_sky_r = SKY_R_NIGHT;
        w_sky_b = w_night_b;
      end
      DAWN: begin
        w_sky_r = SKY_R_DAWN;
        w_sky_b = clamp15(w_g + SKY_B_OFF_DAWN);
      end
      default: ;
    endcase
  end

  // Stripes alternate every 16 scrolled columns and every 8 lines.
  assign w_grass_g = ((w_phase_eff == NIGHT) ? GRASS_G_NIGHT : GRASS_G_DAY) +
                     ((w_xs[4] ^ vCount[3]) ? GRASS_STRIPE : 4'd0);
  assign w_grass   = {4'd0, w_grass_g, GRASS_B};

  always_comb begin
    if (!bright)                                w_rgb = BLACK;
    else if (w_blade_row && blade_col(w_xs))    w_rgb = w_grass;
    else if (vCount < HOR_Y)                    w_rgb = {w_sky_r, 4'd0, w_sky_b};
    else                                        w_rgb = w_grass;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rgb <= BLACK;
    else        r_rgb <= w_rgb;
  end

  assign rgb   = r_rgb;
  assign phase = w_phase;

endmodule
